// File: rtl/mrr_window_sched.sv
// Integration-window scheduler: tags a valid/ready sample stream with first/last
// markers so every window holds exactly 2^cur_log2 samples; config swaps only on boundaries.
module mrr_window_sched #(
  parameter int LOG2_WIDTH = 4,
  parameter int WCNT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [LOG2_WIDTH-1:0] cfg_log2_in,
  input  logic                  cfg_load_in,
  input  logic                  en_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_first,
  output logic                  out_last,
  output logic [LOG2_WIDTH-1:0] cur_log2_out,
  output logic [WCNT_WIDTH-1:0] win_count_out,
  output logic                  cfg_pending_out,
  output logic                  idle_out
);
  localparam int IDX_W = 1 << LOG2_WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

  state_t                state, state_nxt;
  logic [IDX_W-1:0]      idx, mask;
  logic [LOG2_WIDTH-1:0] cur_log2, pend_log2;
  logic                  pending;
  logic                  accept, at_end, boundary;

  assign mask     = (IDX_W'(1) << cur_log2) - IDX_W'(1);
  assign in_ready = (state != IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign at_end   = (idx == mask);
  assign boundary = accept && at_end;

  assign cur_log2_out    = cur_log2;
  assign cfg_pending_out = pending;
  assign idle_out        = (state == IDLE) && !out_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // A stop request only takes effect on a window boundary (or before a window starts).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (en_in) state_nxt = RUN;
      RUN: begin
        if (!en_in) begin
          if (boundary || (idx == '0 && !accept)) state_nxt = IDLE;
          else                                    state_nxt = STOPPING;
        end
      end
      STOPPING: begin
        if (en_in)         state_nxt = RUN;
        else if (boundary) state_nxt = IDLE;
      end
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx           <= '0;
      win_count_out <= '0;
      out_valid     <= 1'b0;
      out_first     <= 1'b0;
      out_last      <= 1'b0;
      cur_log2      <= '0;
      pend_log2     <= '0;
      pending       <= 1'b0;
    end else begin
      if (state == IDLE)  idx <= '0;
      else if (accept)    idx <= at_end ? '0 : idx + IDX_W'(1);

      if (boundary) win_count_out <= win_count_out + WCNT_WIDTH'(1);

      // Output register reloads on the same cycle it drains: 1 sample/clk.
      if (accept) begin
        out_valid <= 1'b1;
        out_first <= (idx == '0);
        out_last  <= at_end;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      // A load coinciding with a boundary beats the older pending value.
      if (state == IDLE) begin
        if (cfg_load_in) cur_log2 <= cfg_log2_in;
      end else if (boundary || state_nxt == IDLE) begin
        if (cfg_load_in)  cur_log2 <= cfg_log2_in;
        else if (pending) cur_log2 <= pend_log2;
        pending <= 1'b0;
      end else if (cfg_load_in) begin
        pend_log2 <= cfg_log2_in;
        pending   <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mrr_window_sched.sv
// Directed bench for mrr_window_sched: window tagging, backpressure, reconfig,
// graceful stop, extreme window lengths and async reset.
module tb_mrr_window_sched;
  localparam int LW = 4;
  localparam int WW = 16;

  logic          clk;
  logic          rst;
  logic [LW-1:0] cfg_log2;
  logic          cfg_load;
  logic          en;
  logic          in_valid;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready;
  logic          out_first;
  logic          out_last;
  logic [LW-1:0] cur_log2;
  logic [WW-1:0] win_count;
  logic          cfg_pending;
  logic          idle;

  int checks = 0;
  int errors = 0;
  int acc_cnt = 0;
  logic [1:0] log_q[$];

  mrr_window_sched #(.LOG2_WIDTH(LW), .WCNT_WIDTH(WW)) dut (
    .clk(clk), .rst(rst), .cfg_log2_in(cfg_log2), .cfg_load_in(cfg_load),
    .en_in(en), .in_valid(in_valid), .in_ready(in_ready), .out_valid(out_valid),
    .out_ready(out_ready), .out_first(out_first), .out_last(out_last),
    .cur_log2_out(cur_log2), .win_count_out(win_count),
    .cfg_pending_out(cfg_pending), .idle_out(idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record accepted inputs and delivered {first,last} tags.
  always @(posedge clk) begin
    if (in_valid && in_ready) acc_cnt++;
    if (out_valid && out_ready) log_q.push_back({out_first, out_last});
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_idle(input logic [LW-1:0] v);
    cfg_log2 = v;
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cfg_log2 = '0; cfg_load = 1'b0; en = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    tick(); tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0h want 0", out_valid); end
    checks++; if ({out_first, out_last} !== 2'b00) begin errors++; $display("FAIL reset_tags got %0h want 0", {out_first, out_last}); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %0h want 0", in_ready); end
    checks++; if (cur_log2 !== '0 || win_count !== '0 || cfg_pending !== 1'b0) begin
      errors++; $display("FAIL reset_regs got cur=%0h win=%0h pend=%0h want 0 0 0", cur_log2, win_count, cfg_pending); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle got %0h want 1", idle); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int qb, ab;
    logic [1:0] e;
    load_idle(2);
    checks++; if (cur_log2 !== 4'd2 || cfg_pending !== 1'b0) begin
      errors++; $display("FAIL basic_idle_load got cur=%0d pend=%0h want 2 0", cur_log2, cfg_pending); end
    en = 1'b1; tick();
    out_ready = 1'b1; in_valid = 1'b1; qb = log_q.size(); ab = acc_cnt;
    tick();
    checks++; if ({out_valid, out_first, out_last} !== 3'b110) begin
      errors++; $display("FAIL basic_first_latency got %0b want 110", {out_valid, out_first, out_last}); end
    repeat (11) tick();
    in_valid = 1'b0; tick();
    checks++; if (acc_cnt - ab !== 12 || log_q.size() - qb !== 12) begin
      errors++; $display("FAIL basic_count got acc=%0d out=%0d want 12 12", acc_cnt - ab, log_q.size() - qb); end
    checks++; if (win_count !== 16'd3) begin errors++; $display("FAIL basic_win_count got %0d want 3", win_count); end
    for (int i = 0; i < 12 && qb + i < log_q.size(); i++) begin
      e = {(i % 4 == 0), (i % 4 == 3)};
      checks++; if (log_q[qb+i] !== e) begin errors++; $display("FAIL basic_tag[%0d] got %0b want %0b", i, log_q[qb+i], e); end
    end
    en = 1'b0; tick(); tick();
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL basic_stop_idle got %0h want 1", idle); end
  endtask

  task automatic test_backpressure();
    int qb, ab;
    logic stall, pf, pl;
    logic [1:0] e;
    load_idle(3); en = 1'b1; tick();
    qb = log_q.size(); ab = acc_cnt; in_valid = 1'b1;
    for (int c = 0; c < 40 && (acc_cnt - ab) < 8; c++) begin
      out_ready = (c % 2 == 0);
      stall = out_valid && !out_ready; pf = out_first; pl = out_last;
      tick();
      if (acc_cnt - ab >= 8) in_valid = 1'b0;
      if (stall) begin
        checks++; if ({out_valid, out_first, out_last} !== {1'b1, pf, pl}) begin
          errors++; $display("FAIL bp_stall_stable got %0b want %0b", {out_valid, out_first, out_last}, {1'b1, pf, pl}); end
      end
    end
    in_valid = 1'b0; out_ready = 1'b1; tick(); tick();
    checks++; if (acc_cnt - ab !== 8 || log_q.size() - qb !== 8) begin
      errors++; $display("FAIL bp_count got acc=%0d out=%0d want 8 8", acc_cnt - ab, log_q.size() - qb); end
    for (int i = 0; i < 8 && qb + i < log_q.size(); i++) begin
      e = {(i == 0), (i == 7)};
      checks++; if (log_q[qb+i] !== e) begin errors++; $display("FAIL bp_tag[%0d] got %0b want %0b", i, log_q[qb+i], e); end
    end
    checks++; if (win_count !== 16'd4) begin errors++; $display("FAIL bp_win_count got %0d want 4", win_count); end
    en = 1'b0; tick(); tick();
  endtask

  task automatic test_reconfig();
    int qb;
    logic [WW-1:0] wb;
    logic [1:0] e;
    load_idle(2); en = 1'b1; tick();
    qb = log_q.size(); wb = win_count; in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 13; k++) begin
      cfg_load = (k == 1 || k == 2 || k == 11);
      cfg_log2 = (k == 1) ? 4'd1 : (k == 2) ? 4'd3 : 4'd0;
      tick();
      if (k == 1 || k == 2) begin
        checks++; if (cfg_pending !== 1'b1 || cur_log2 !== 4'd2) begin
          errors++; $display("FAIL rc_pending_k%0d got pend=%0h cur=%0d want 1 2", k, cfg_pending, cur_log2); end
      end
      if (k == 3) begin
        checks++; if (cfg_pending !== 1'b0 || cur_log2 !== 4'd3) begin
          errors++; $display("FAIL rc_apply got pend=%0h cur=%0d want 0 3", cfg_pending, cur_log2); end
      end
      if (k == 11) begin
        checks++; if (cfg_pending !== 1'b0 || cur_log2 !== 4'd0) begin
          errors++; $display("FAIL rc_same_edge got pend=%0h cur=%0d want 0 0", cfg_pending, cur_log2); end
      end
    end
    cfg_load = 1'b0; in_valid = 1'b0; tick();
    checks++; if (log_q.size() - qb !== 13) begin errors++; $display("FAIL rc_count got %0d want 13", log_q.size() - qb); end
    for (int i = 0; i < 13 && qb + i < log_q.size(); i++) begin
      e = {(i == 0 || i == 4 || i == 12), (i == 3 || i == 11 || i == 12)};
      checks++; if (log_q[qb+i] !== e) begin errors++; $display("FAIL rc_tag[%0d] got %0b want %0b", i, log_q[qb+i], e); end
    end
    checks++; if (win_count !== wb + 16'd3) begin errors++; $display("FAIL rc_win_count got %0d want %0d", win_count, wb + 16'd3); end
    en = 1'b0; tick(); tick();
  endtask

  task automatic test_stop();
    int qb, ab;
    logic [WW-1:0] wb;
    load_idle(2); en = 1'b1; tick();
    qb = log_q.size(); ab = acc_cnt; wb = win_count; in_valid = 1'b1; out_ready = 1'b1;
    tick(); tick();
    en = 1'b0; tick();
    checks++; if (in_ready !== 1'b1 || idle !== 1'b0) begin
      errors++; $display("FAIL stop_still_running got rdy=%0h idle=%0h want 1 0", in_ready, idle); end
    tick();
    out_ready = 1'b0; #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stop_in_ready got %0h want 0", in_ready); end
    checks++; if ({out_valid, out_last, idle} !== 3'b110) begin
      errors++; $display("FAIL stop_draining got %0b want 110", {out_valid, out_last, idle}); end
    tick();
    checks++; if (acc_cnt - ab !== 4) begin errors++; $display("FAIL stop_accepts got %0d want 4", acc_cnt - ab); end
    out_ready = 1'b1; tick();
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL stop_idle got %0h want 1", idle); end
    checks++; if (win_count !== wb + 16'd1) begin errors++; $display("FAIL stop_win_count got %0d want %0d", win_count, wb + 16'd1); end
    checks++; if (log_q.size() - qb !== 4 || log_q[log_q.size()-1] !== 2'b01) begin
      errors++; $display("FAIL stop_last_tag got n=%0d tag=%0b want 4 01", log_q.size() - qb, log_q[log_q.size()-1]); end
    in_valid = 1'b0;
  endtask

  task automatic test_extremes();
    int qb, ab, nf, nl, pf, pl;
    logic [WW-1:0] wb;
    load_idle(0); en = 1'b1; tick();
    qb = log_q.size(); wb = win_count; in_valid = 1'b1; out_ready = 1'b1;
    repeat (5) tick();
    in_valid = 1'b0; tick();
    checks++; if (win_count !== wb + 16'd5) begin errors++; $display("FAIL l0_win_count got %0d want %0d", win_count, wb + 16'd5); end
    for (int i = 0; i < 5 && qb + i < log_q.size(); i++) begin
      checks++; if (log_q[qb+i] !== 2'b11) begin errors++; $display("FAIL l0_tag[%0d] got %0b want 11", i, log_q[qb+i]); end
    end
    en = 1'b0; tick(); tick();
    load_idle(15);
    checks++; if (cur_log2 !== 4'd15) begin errors++; $display("FAIL lmax_cur got %0d want 15", cur_log2); end
    en = 1'b1; tick();
    qb = log_q.size(); ab = acc_cnt; wb = win_count; in_valid = 1'b1;
    repeat (32768) tick();
    in_valid = 1'b0; tick();
    nf = 0; nl = 0; pf = -1; pl = -1;
    for (int i = qb; i < log_q.size(); i++) begin
      if (log_q[i][1]) begin nf++; pf = i - qb; end
      if (log_q[i][0]) begin nl++; pl = i - qb; end
    end
    checks++; if (acc_cnt - ab !== 32768) begin errors++; $display("FAIL lmax_accepts got %0d want 32768", acc_cnt - ab); end
    checks++; if (nf !== 1 || pf !== 0) begin errors++; $display("FAIL lmax_first got n=%0d pos=%0d want 1 0", nf, pf); end
    checks++; if (nl !== 1 || pl !== 32767) begin errors++; $display("FAIL lmax_last got n=%0d pos=%0d want 1 32767", nl, pl); end
    checks++; if (win_count !== wb + 16'd1) begin errors++; $display("FAIL lmax_win_count got %0d want %0d", win_count, wb + 16'd1); end
    en = 1'b0; tick(); tick();
  endtask

  task automatic test_async_reset();
    int qb;
    logic [1:0] e;
    load_idle(2); en = 1'b1; tick();
    in_valid = 1'b1; out_ready = 1'b0; tick();
    in_valid = 1'b0; #2;
    checks++; if ({out_valid, out_first} !== 2'b11) begin
      errors++; $display("FAIL ar_precond got %0b want 11", {out_valid, out_first}); end
    rst = 1'b1; #1;
    checks++; if ({out_valid, out_first, out_last, in_ready} !== 4'b0000) begin
      errors++; $display("FAIL ar_outputs got %0b want 0000", {out_valid, out_first, out_last, in_ready}); end
    checks++; if (cur_log2 !== '0 || win_count !== '0 || cfg_pending !== 1'b0 || idle !== 1'b1) begin
      errors++; $display("FAIL ar_regs got cur=%0d win=%0d pend=%0h idle=%0h want 0 0 0 1", cur_log2, win_count, cfg_pending, idle); end
    en = 1'b0; #1; rst = 1'b0;
    tick();
    load_idle(2); en = 1'b1; tick();
    qb = log_q.size(); in_valid = 1'b1; out_ready = 1'b1;
    repeat (4) tick();
    in_valid = 1'b0; tick();
    checks++; if (log_q.size() - qb !== 4) begin errors++; $display("FAIL ar_count got %0d want 4", log_q.size() - qb); end
    for (int i = 0; i < 4 && qb + i < log_q.size(); i++) begin
      e = {(i == 0), (i == 3)};
      checks++; if (log_q[qb+i] !== e) begin errors++; $display("FAIL ar_tag[%0d] got %0b want %0b", i, log_q[qb+i], e); end
    end
    checks++; if (win_count !== 16'd1) begin errors++; $display("FAIL ar_win_count got %0d want 1", win_count); end
    en = 1'b0; tick(); tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_reconfig();
    test_stop();
    test_extremes();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
